// File: rtl/music_sequencer.sv
// Music playback sequencer: fetches note words, decodes NOTE/REST/END/SKIP and drives period/gate.
// Optional build macro MUSIC_SEQUENCER_LOOP_EN: END restarts the song from address 0.
module music_sequencer #(
  parameter int ADDR_W        = 8,
  parameter int CLKS_PER_BEAT = 25000,
  parameter int PERIOD_W      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [31:0]         mem_data,
  output logic [PERIOD_W-1:0] period,
  output logic                gate,
  output logic                busy,
  output logic                done,
  output logic [2:0]          dbg_state
);

  localparam int CNT_W = (CLKS_PER_BEAT > 1) ? $clog2(CLKS_PER_BEAT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BEAT - 1);

  localparam logic [7:0] OP_NOTE = 8'h00;
  localparam logic [7:0] OP_REST = 8'h22;
  localparam logic [7:0] OP_END  = 8'h11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  ptr;
  logic [7:0]         beats;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         op;
  logic [7:0]         dur;

  assign op  = mem_data[31:24];
  assign dur = mem_data[23:16];

  // Read protocol: mem_rd_en is high for the single FETCH cycle; mem_data is
  // valid in the following LOAD cycle and sampled at the edge that ends it.
  assign mem_rd_en = (state == FETCH);
  assign mem_addr  = ptr;
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ptr    <= '0;
      beats  <= '0;
      cnt    <= '0;
      period <= '0;
      gate   <= 1'b0;
    end else if (stop) begin
      state  <= IDLE;
      ptr    <= '0;
      beats  <= '0;
      cnt    <= '0;
      period <= '0;
      gate   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          cnt <= '0;
          if ((op == OP_NOTE || op == OP_REST) && dur != 8'd0) begin
            period <= (op == OP_NOTE) ? PERIOD_W'(mem_data[15:0]) : '0;
            gate   <= (op == OP_NOTE);
            beats  <= dur;
            ptr    <= ptr + ADDR_W'(1);
            state  <= PLAY;
          end else if (op == OP_END) begin
            period <= '0;
            gate   <= 1'b0;
`ifdef MUSIC_SEQUENCER_LOOP_EN
            // An END at address 0 is an empty song; looping it would spin forever.
            if (ptr != '0) begin
              ptr   <= '0;
              state <= FETCH;
            end else begin
              state <= DONE;
            end
`else
            state <= DONE;
`endif
          end else begin
            ptr   <= ptr + ADDR_W'(1);
            state <= FETCH;
          end
        end
        PLAY: begin
          if (cnt == CNT_MAX) begin
            cnt   <= '0;
            beats <= beats - 8'd1;
            if (beats == 8'd1) state <= FETCH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (start) begin
            ptr   <= '0;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer: decode table, directed corner cases and
// randomized songs compared against a cycle trace derived from the word-format rules.
module tb_music_sequencer;

  localparam int ADDR_W = 4;
  localparam int CPB    = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] END_W = 32'h11000000;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              stop;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic [15:0]       period;
  logic              gate;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;

  logic [31:0] mem [DEPTH];
  logic [23:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  music_sequencer #(.ADDR_W(ADDR_W), .CLKS_PER_BEAT(CPB), .PERIOD_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .period(period), .gate(gate), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset / memory
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= mem[mem_addr];
  end

  typedef struct {
    logic [31:0] word;
    logic        exp_gate;
    logic [15:0] exp_period;
    logic        exp_rd;
    logic [3:0]  exp_addr;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [23:0] pk(logic rd, logic [3:0] a, logic [15:0] p,
                                     logic g, logic b, logic d);
    return {rd, a, p, g, b, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic stop_pulse();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic fill_mem(input logic [31:0] w);
    for (int i = 0; i < DEPTH; i++) mem[i] = w;
  endtask

  // Reference: walk the song word by word and emit what each cycle should show,
  // starting with the FETCH cycle that follows the start capture.
  task automatic build_trace(input int max);
    int unsigned ptr;
    logic [15:0] per;
    logic        g;
    logic [31:0] w;
    logic [7:0]  op;
    int          dur;
    bit          fin;
    ptr = 0; per = '0; g = 1'b0; fin = 0;
    exp_q.delete();
    while (exp_q.size() < max && !fin) begin
      exp_q.push_back(pk(1'b1, ptr[3:0], per, g, 1'b1, 1'b0));
      exp_q.push_back(pk(1'b0, ptr[3:0], per, g, 1'b1, 1'b0));
      w = mem[ptr]; op = w[31:24]; dur = int'(w[23:16]);
      if (op == 8'h11) begin
        per = '0; g = 1'b0;
`ifdef MUSIC_SEQUENCER_LOOP_EN
        if (ptr != 0) ptr = 0;
        else fin = 1;
`else
        fin = 1;
`endif
      end else if ((op == 8'h00 || op == 8'h22) && dur > 0) begin
        per = (op == 8'h00) ? w[15:0] : 16'h0;
        g   = (op == 8'h00);
        ptr = (ptr + 1) % DEPTH;
        for (int k = 0; k < dur * CPB; k++) exp_q.push_back(pk(1'b0, ptr[3:0], per, g, 1'b1, 1'b0));
      end else begin
        ptr = (ptr + 1) % DEPTH;
      end
    end
    while (exp_q.size() < max) exp_q.push_back(pk(1'b0, ptr[3:0], 16'h0, 1'b0, 1'b0, 1'b1));
  endtask

  // scoreboard: start the song, then compare one expected record per cycle
  task automatic run_trace(input string name, input int max, input int poke);
    logic [23:0] e;
    build_trace(max);
    do_start();
    for (int i = 0; i < max; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d]", name, i),
          {8'h0, pk(mem_rd_en, mem_addr, period, gate, busy, done)}, {8'h0, e});
      start = (i == poke) && e[1];
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0;
    fill_mem(END_W);
    repeat (3) @(negedge clk);
    chk("rst_gate", gate, 0);
    chk("rst_period", period, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // single-word decode table: observe two cycles after the FETCH cycle
    vecs[0] = '{32'h00030abc, 1'b1, 16'h0abc, 1'b0, 4'd1, 1'b1, 1'b0};
    vecs[1] = '{32'h22020123, 1'b0, 16'h0000, 1'b0, 4'd1, 1'b1, 1'b0};
    vecs[2] = '{32'h00000777, 1'b0, 16'h0000, 1'b1, 4'd1, 1'b1, 1'b0};
    vecs[3] = '{32'h22000000, 1'b0, 16'h0000, 1'b1, 4'd1, 1'b1, 1'b0};
    vecs[4] = '{32'h7f0155aa, 1'b0, 16'h0000, 1'b1, 4'd1, 1'b1, 1'b0};
    vecs[5] = '{32'hff02ffff, 1'b0, 16'h0000, 1'b1, 4'd1, 1'b1, 1'b0};
    vecs[6] = '{32'h11000000, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[7] = '{32'h11ff1234, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[8] = '{32'h01010101, 1'b0, 16'h0000, 1'b1, 4'd1, 1'b1, 1'b0};
    for (int v = 0; v < 9; v++) begin
      fill_mem(END_W);
      mem[0] = vecs[v].word;
      stop_pulse();
      do_start();
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_gate", v), gate, vecs[v].exp_gate);
      chk($sformatf("vec%0d_period", v), period, vecs[v].exp_period);
      chk($sformatf("vec%0d_rd", v), mem_rd_en, vecs[v].exp_rd);
      chk($sformatf("vec%0d_addr", v), mem_addr, vecs[v].exp_addr);
      chk($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
      chk($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
    end

    // basic note timing
    fill_mem(END_W);
    mem[0] = 32'h00020100;
    stop_pulse();
    do_start();
    repeat (2) @(negedge clk);
    chk("basic_gate_on", gate, 1);
    chk("basic_period", period, 16'h0100);
    n = 0;
    while (gate && n < 50) begin n++; @(negedge clk); end
    chk("basic_len", n, 10);
    chk("basic_end_period", period, 0);
    chk("basic_end_done", done, 1);
    chk("basic_end_busy", busy, 0);

    // rest / skip / zero-duration sequence
    fill_mem(END_W);
    mem[0] = 32'h22010000; mem[1] = 32'h55000000; mem[2] = 32'h00000200;
    mem[3] = 32'h00010300; mem[4] = END_W;
    stop_pulse();
    run_trace("rest_seq", 26, -1);

    // start pulsed during PLAY must not disturb the address sequence
    fill_mem(END_W);
    mem[0] = 32'h00020111; mem[1] = 32'h22010000; mem[2] = 32'h00010222;
    stop_pulse();
    run_trace("start_in_play", 30, 5);

    // pointer wrap with no END word
    fill_mem(32'h55000000);
    mem[15] = 32'h00010abc;
    stop_pulse();
    run_trace("wrap", 44, -1);

    // stop mid-note
    fill_mem(END_W);
    mem[0] = 32'h00040100;
    stop_pulse();
    do_start();
    repeat (2) @(negedge clk);
    chk("stop_gate_pre", gate, 1);
    repeat (2) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop_gate", gate, 0);
    chk("stop_period", period, 0);
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    do_start();
    chk("restart_rd", mem_rd_en, 1);
    chk("restart_addr", mem_addr, 0);

    // async reset mid-PLAY
    repeat (3) @(negedge clk);
    chk("arst_gate_pre", gate, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_gate", gate, 0);
    chk("arst_period", period, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("arst_quiet%0d", i), {30'h0, mem_rd_en, busy}, 0);
    end

    // start and stop together in IDLE
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("startstop_state", dbg_state, 0);
    chk("startstop_busy", busy, 0);
    @(negedge clk);
    chk("startstop_rd", mem_rd_en, 0);

    // loop behaviour (DONE vs restart depends on the build)
    fill_mem(32'h55000000);
    mem[0] = 32'h00010100; mem[1] = END_W;
    stop_pulse();
    run_trace("loop2", 30, -1);
    mem[0] = END_W;
    stop_pulse();
    run_trace("empty", 6, -1);

    // randomized songs
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        int pick;
        logic [7:0] op;
        pick = $urandom_range(0, 9);
        if (pick < 4) op = 8'h00;
        else if (pick < 6) op = 8'h22;
        else if (pick == 6) op = 8'h11;
        else op = 8'(8'h30 + $urandom_range(0, 64));
        mem[i] = {op, 8'($urandom_range(0, 2)), 16'($urandom)};
      end
      stop_pulse();
      run_trace($sformatf("rand%0d", r), 120, $urandom_range(3, 60));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
